// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux, with a hold-time limit
// so a busy owner is rotated out once another requester has waited long enough.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       rot,
    output logic       y
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] owner, owner_n;
    logic [7:0] hold_cnt, hold_n;
    logic       rot_n;
    logic [3:0] gnt_n;
    logic       busy_n;
    logic [3:0] others;
    logic [2:0] win;

    // Returns {found, index} of the first set mask bit scanning upward from start, mod 4.
    function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) begin
                pick = {1'b1, idx};
            end
        end
    endfunction

    // State register: FSM, arbitration state and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            hold_cnt <= 8'd0;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            rot      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            rot      <= rot_n;
        end
    end

    // Next-state logic: release is tested before timeout, so a dropping owner never rotates.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold_cnt;
        rot_n   = 1'b0;
        others  = req & ~(4'b0001 << owner);
        win     = 3'b000;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    win     = pick(req, ptr);
                    state_n = GRANT;
                    owner_n = win[1:0];
                    hold_n  = 8'd0;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    ptr_n  = owner + 2'd1;
                    win    = pick(others, owner + 2'd1);
                    hold_n = 8'd0;
                    if (win[2]) begin
                        owner_n = win[1:0];
                    end else begin
                        state_n = IDLE;
                        owner_n = 2'd0;
                    end
                end else if (hold_cnt == HOLD_LAST && others != 4'b0000) begin
                    ptr_n   = owner + 2'd1;
                    win     = pick(others, owner + 2'd1);
                    owner_n = win[1:0];
                    hold_n  = 8'd0;
                    rot_n   = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_n = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = 2'd0;
                hold_n  = 8'd0;
            end
        endcase
    end

    // Output decode of the upcoming state, registered above so gnt cannot glitch.
    always_comb begin
        gnt_n  = 4'b0000;
        busy_n = 1'b0;
        if (state_n == GRANT) begin
            gnt_n  = 4'b0001 << owner_n;
            busy_n = 1'b1;
        end
    end

    assign sel = owner;
    assign y   = busy ? d[sel] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with MAX_HOLD=4 and hand-computed expectations.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       rot;
    logic       y;

    int compared;
    int mismatched;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .rot   (rot),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] reqv, input logic [3:0] dv);
        req = reqv;
        d   = dv;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset held with all requesters active.
        rst_n = 1'b0;
        applyStimulus(4'b1111, 4'b1010);
        stepCycle();
        stepCycle();
        checkOutput("rst_gnt",  8'(gnt),  8'h00);
        checkOutput("rst_sel",  8'(sel),  8'h00);
        checkOutput("rst_busy", 8'(busy), 8'h00);
        checkOutput("rst_rot",  8'(rot),  8'h00);
        checkOutput("rst_y",    8'(y),    8'h00);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("first_gnt",  8'(gnt),  8'h01);
        checkOutput("first_sel",  8'(sel),  8'h00);
        checkOutput("first_y",    8'(y),    8'h00);
        checkOutput("first_busy", 8'(busy), 8'h01);

        // Drop everything; owner 0 releases to idle.
        applyStimulus(4'b0000, 4'b1010);
        stepCycle();
        checkOutput("idle_gnt",  8'(gnt),  8'h00);
        checkOutput("idle_busy", 8'(busy), 8'h00);

        // Single requester 2 for three cycles.
        applyStimulus(4'b0100, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("single_gnt", 8'(gnt), 8'h04);
            checkOutput("single_sel", 8'(sel), 8'h02);
            checkOutput("single_y",   8'(y),   8'h01);
            checkOutput("single_rot", 8'(rot), 8'h00);
        end
        d = 4'b0000;
        #1;
        checkOutput("y_comb_low", 8'(y), 8'h00);
        d = 4'b0101;
        #1;
        checkOutput("y_comb_high", 8'(y), 8'h01);
        applyStimulus(4'b0000, 4'b0101);
        stepCycle();
        checkOutput("single_drop_gnt",  8'(gnt),  8'h00);
        checkOutput("single_drop_busy", 8'(busy), 8'h00);

        // Pulse reset between edges so the rotation starts from ptr 0.
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // Fair rotation with all four requesting.
        applyStimulus(4'b1111, 4'b0000);
        for (int i = 0; i <= 16; i++) begin
            stepCycle();
            checkOutput("rot_gnt",   8'(gnt), 8'(4'b0001 << ((i / 4) % 4)));
            checkOutput("rot_pulse", 8'(rot), ((i % 4 == 0) && (i > 0)) ? 8'h01 : 8'h00);
        end

        // Zero-bubble handover from owner 0 to owner 3.
        applyStimulus(4'b1001, 4'b0000);
        stepCycle();
        checkOutput("zb_pre_gnt", 8'(gnt), 8'h01);
        applyStimulus(4'b1000, 4'b0000);
        stepCycle();
        checkOutput("zb_gnt",  8'(gnt),  8'h08);
        checkOutput("zb_busy", 8'(busy), 8'h01);
        checkOutput("zb_rot",  8'(rot),  8'h00);
        checkOutput("zb_sel",  8'(sel),  8'h03);

        // Owner 3 releases; requester 1 alone is never preempted.
        applyStimulus(4'b0010, 4'b0010);
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput("alone_gnt", 8'(gnt), 8'h02);
            checkOutput("alone_rot", 8'(rot), 8'h00);
        end
        applyStimulus(4'b1010, 4'b0010);
        stepCycle();
        checkOutput("late_gnt", 8'(gnt), 8'h08);
        checkOutput("late_rot", 8'(rot), 8'h01);
        stepCycle();
        checkOutput("late_gnt2", 8'(gnt), 8'h08);
        checkOutput("late_rot2", 8'(rot), 8'h00);

        // Async reset mid-grant, then wrap-around check from ptr 0.
        applyStimulus(4'b1010, 4'b1000);
        #1;
        checkOutput("mid_y", 8'(y), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_gnt",  8'(gnt),  8'h00);
        checkOutput("mid_rst_busy", 8'(busy), 8'h00);
        checkOutput("mid_rst_y",    8'(y),    8'h00);
        applyStimulus(4'b1001, 4'b0001);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("post_rst_gnt", 8'(gnt), 8'h01);
        checkOutput("post_rst_y",   8'(y),   8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
